// File: rtl/mc_control_fsm.sv
// Main control unit for the multicycle MIPS datapath: Moore FSM driving every
// mux select and write enable, plus ALU-operation decode from opcode and funct.
module mc_control_fsm (
    input  logic       CLK,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State,
    output logic       InstrDone,
    output logic       IllegalOp
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    state_e     state_q;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    case (Op)
                        OpLw, OpSw: state_q <= StMemAdr;
                        OpRtype:    state_q <= StExecute;
                        OpBeq:      state_q <= StBranch;
                        OpAddi:     state_q <= StAddiEx;
                        OpJ:        state_q <= StJump;
                        default:    state_q <= StFetch;
                    endcase
                end
                StMemAdr:  state_q <= (Op == OpLw) ? StMemRd : StMemWr;
                StMemRd:   state_q <= StMemWb;
                StExecute: state_q <= StAluWb;
                StAddiEx:  state_q <= StAddiWb;
                default:   state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        branch    = 1'b0;
        alu_op    = 2'b00;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            StDecode: begin
                ALUSrcB   = 2'b11;
                IllegalOp = !(Op inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ});
            end
            StMemAdr, StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: IorD = 1'b1;
            StMemWb: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StMemWr: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            StAluWb: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StBranch: begin
                ALUSrcA   = 1'b1;
                alu_op    = 2'b01;
                PCSrc     = 2'b01;
                branch    = 1'b1;
                InstrDone = 1'b1;
            end
            StAddiWb: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StJump: begin
                PCSrc     = 2'b10;
                pc_write  = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts in-flight writes in the same cycle it is seen.
        if (rst) begin
            pc_write  = 1'b0;
            branch    = 1'b0;
            alu_op    = 2'b00;
            IorD      = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            PCSrc     = 2'b00;
            InstrDone = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b010;
        if (alu_op == 2'b01) begin
            ALUControl = 3'b110;
        end else if (alu_op == 2'b10) begin
            case (Funct)
                6'b100010: ALUControl = 3'b110;
                6'b100100: ALUControl = 3'b000;
                6'b100101: ALUControl = 3'b001;
                6'b101010: ALUControl = 3'b111;
                default:   ALUControl = 3'b010;
            endcase
        end
    end

    assign PCEn  = pc_write | (branch & Zero);
    assign State = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: walks lw, R-type, beq, illegal,
// sw-with-reset and j through the FSM and checks state and control outputs.
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       InstrDone, IllegalOp;

    int checks = 0;
    int errors = 0;

    mc_control_fsm dut (
        .CLK        (CLK),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .InstrDone  (InstrDone),
        .IllegalOp  (IllegalOp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
    logic [2:0] ac_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};

    initial begin
        rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        tick(); tick();
        chk("rst_state", 8'(State), 8'd0);
        chk("rst_pcen", 8'(PCEn), 8'd0);
        chk("rst_irwrite", 8'(IRWrite), 8'd0);
        chk("rst_aluctl", 8'(ALUControl), 8'b010);
        chk("rst_alusrcb", 8'(ALUSrcB), 8'd0);

        // lw
        rst = 1'b0; Op = 6'b100011; #1;
        chk("fetch_state", 8'(State), 8'd0);
        chk("fetch_pcen", 8'(PCEn), 8'd1);
        chk("fetch_irwrite", 8'(IRWrite), 8'd1);
        chk("fetch_alusrcb", 8'(ALUSrcB), 8'b01);
        tick();
        chk("lw_s1", 8'(State), 8'd1);
        chk("dec_alusrcb", 8'(ALUSrcB), 8'b11);
        chk("dec_pcen", 8'(PCEn), 8'd0);
        chk("lw_s1_done", 8'(InstrDone), 8'd0);
        tick();
        chk("lw_s2", 8'(State), 8'd2);
        chk("memadr_srcs", 8'({ALUSrcA, ALUSrcB}), 8'b110);
        tick();
        chk("lw_s3", 8'(State), 8'd3);
        chk("memrd_iord", 8'(IorD), 8'd1);
        chk("memrd_done", 8'(InstrDone), 8'd0);
        tick();
        chk("lw_s4", 8'(State), 8'd4);
        chk("memwb_ctl", 8'({RegDst, MemtoReg, RegWrite, InstrDone}), 8'b0111);
        tick();
        chk("lw_end", 8'(State), 8'd0);
        chk("lw_end_done", 8'(InstrDone), 8'd0);

        // R-type slt, then sweep the rest of the funct table while in EXECUTE
        Op = 6'b000000; Funct = 6'b101010;
        tick();
        chk("r_s1", 8'(State), 8'd1);
        tick();
        chk("r_s6", 8'(State), 8'd6);
        chk("exec_slt", 8'(ALUControl), 8'b111);
        chk("exec_srcs", 8'({ALUSrcA, ALUSrcB}), 8'b100);
        for (int i = 0; i < 5; i++) begin
            Funct = fn_tab[i]; #1;
            chk("exec_funct", 8'(ALUControl), 8'(ac_tab[i]));
        end
        tick();
        chk("r_s7", 8'(State), 8'd7);
        chk("aluwb_ctl", 8'({RegDst, RegWrite, InstrDone}), 8'b111);
        tick();
        chk("r_end", 8'(State), 8'd0);

        // beq
        Op = 6'b000100;
        tick(); tick();
        chk("beq_s8", 8'(State), 8'd8);
        Zero = 1'b1; #1;
        chk("beq_pcen_z1", 8'(PCEn), 8'd1);
        chk("beq_pcsrc", 8'(PCSrc), 8'b01);
        chk("beq_aluctl", 8'(ALUControl), 8'b110);
        Zero = 1'b0; #1;
        chk("beq_pcen_z0", 8'(PCEn), 8'd0);
        chk("beq_done", 8'(InstrDone), 8'd1);
        tick();
        chk("beq_end", 8'(State), 8'd0);

        // illegal opcode
        Op = 6'b111111;
        tick();
        chk("ill_s1", 8'(State), 8'd1);
        chk("ill_pulse", 8'(IllegalOp), 8'd1);
        chk("ill_writes", 8'({RegWrite, MemWrite}), 8'd0);
        tick();
        chk("ill_end", 8'(State), 8'd0);
        chk("ill_pulse_off", 8'(IllegalOp), 8'd0);
        chk("ill_writes2", 8'({RegWrite, MemWrite}), 8'd0);

        // sw aborted by reset in MEMWR
        Op = 6'b101011;
        tick(); tick(); tick();
        chk("sw_s5", 8'(State), 8'd5);
        chk("memwr_ctl", 8'({IorD, MemWrite, InstrDone}), 8'b111);
        rst = 1'b1; #1;
        chk("sw_rst_memwrite", 8'(MemWrite), 8'd0);
        chk("sw_rst_iord", 8'(IorD), 8'd0);
        tick();
        chk("sw_rst_state", 8'(State), 8'd0);
        chk("sw_rst_pcen", 8'(PCEn), 8'd0);

        // j
        rst = 1'b0; Op = 6'b000010; #1;
        chk("j_fetch_pcen", 8'(PCEn), 8'd1);
        tick();
        chk("j_s1", 8'(State), 8'd1);
        tick();
        chk("j_s11", 8'(State), 8'd11);
        chk("jump_ctl", 8'({PCSrc, PCEn, InstrDone}), 8'b1011);
        tick();
        chk("j_end", 8'(State), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control unit for the multicycle MIPS datapath. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable in the datapath, including the combined program-counter enable, and it decodes the ALU operation from opcode and funct. It sits beside the datapath and feeds the PC register, instruction register, register file, memory and ALU.

## Interface
- No parameters; opcode, funct and state encodings are fixed below.
- CLK  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- Op  in  6  opcode, IR[31:26]
- Funct  in  6  funct field, IR[5:0]
- Zero  in  1  ALU zero flag, same cycle
- PCEn  out  1  PC load enable = PCWrite | (Branch & Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUControl  out  3  ALU function
- State  out  4  current state, debug
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- IllegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 are unreachable; if entered, they go to FETCH with all enables 0.
- Transitions:
  - FETCH → DECODE
  - DECODE → MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j), FETCH (illegal, with IllegalOp=1)
  - MEMADR → MEMRD (lw) / MEMWR (sw)
  - MEMRD → MEMWB; EXECUTE → ALUWB; ADDIEX → ADDIWB
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH
- Outputs per state; any signal not listed is 0. ALUOp is internal.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - MEMRD: IorD=1
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1
  - MEMWR: IorD=1, MemWrite=1
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10
  - ALUWB: RegDst=1, RegWrite=1
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - ADDIWB: RegWrite=1
  - JUMP: PCSrc=10, PCWrite=1
- InstrDone is 1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
- ALU decode:
  - ALUOp 00 → 010 (add); ALUOp 01 → 110 (sub); ALUOp 11 → 010.
  - ALUOp 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 010.

## Timing
- The state register is the only storage. All outputs are combinational from State, Op, Funct and Zero.
- While rst=1:
  - every enable output is forced to 0: PCEn, MemWrite, IRWrite, RegWrite, InstrDone, IllegalOp;
  - all selects are 0 and ALUControl=010;
  - State is set to FETCH on the edge.
- First cycle after rst falls: FETCH, with PCEn=1 and IRWrite=1.
- Reset asserted in any state aborts the instruction. The next cycle is FETCH, and no partial write occurs after the reset edge.
- Cycles per instruction, counting from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- BRANCH: PCEn follows Zero in the same cycle, so there is no extra latency.
- Op and Funct are sampled only in DECODE, MEMADR and EXECUTE. The IR must hold them stable from the end of FETCH.

## Test plan
- Reset and fetch: rst=1 for 2 cycles → State=0 and PCEn=0. After release → State=0 with PCEn=1 and IRWrite=1, then State=1.
- lw (Op=100011): State sequence 0,1,2,3,4,0. Check MEMRD IorD=1; MEMWB MemtoReg=1, RegWrite=1; InstrDone only in state 4.
- R-type with Funct=101010: sequence 0,1,6,7,0. ALUControl=111 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB.
- beq in state 8: with Zero=1 → PCEn=1 and PCSrc=01; repeat with Zero=0 → PCEn=0. Both return to FETCH.
- Illegal Op=111111: sequence 0,1,0 with IllegalOp=1 for exactly one cycle. No RegWrite or MemWrite at any point.
- sw (Op=101011): assert rst during state 5 → MemWrite=0 that cycle, FETCH next cycle. Then a j (Op=000010) completes as 0,1,11,0 with PCSrc=10 and PCEn=1.
